// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helper functions for the fifo_ctrl_v2 buffer family.
//   DefWidth / DefDepth : default word width and entry count
//   cnt_width()         : width of an occupancy counter able to hold 0..depth
//   even_parity()       : even-parity bit of a word (zero-extended to MaxParW)
// Optional feature macro used by the users of this package: FIFO_PARITY_EN.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefDepth = 32;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which does not change their parity.
  localparam int unsigned MaxParW = 1024;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Returns the bit that makes the total number of ones (data + bit) even.
  function automatic logic even_parity(input logic [MaxParW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_ctrl_v2_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_v2_if
// Bundles the data/handshake/status signals of fifo_ctrl_v2.
//   slave  : the FIFO side (takes writes, reads, control; drives status)
//   master : the user side (drives requests, observes status)
// Signals: flush, wr_en, wr_data, rd_en, rd_data, rd_valid, full, empty,
//          almost_full, almost_empty, afull_thr, aempty_thr, count,
//          overflow, underflow, clr_err, and parity_err when FIFO_PARITY_EN
//          is defined.
// -----------------------------------------------------------------------------
interface fifo_ctrl_v2_if #(
  parameter int unsigned WIDTH = fifo_pkg::DefWidth,
  parameter int unsigned DEPTH = fifo_pkg::DefDepth
);
  localparam int unsigned CW = fifo_pkg::cnt_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    afull_thr;
  logic [CW-1:0]    aempty_thr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;
`ifdef FIFO_PARITY_EN
  logic             parity_err;
`endif

  modport slave (
`ifdef FIFO_PARITY_EN
    output parity_err,
`endif
    input  flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );

  modport master (
`ifdef FIFO_PARITY_EN
    input  parity_err,
`endif
    output flush, wr_en, wr_data, rd_en, afull_thr, aempty_thr, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port. No reset on the array.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address (0..DEPTH-1)
//   i_wdata  : write data
//   i_raddr  : read address (0..DEPTH-1)
//   o_rdata  : combinational read data
// -----------------------------------------------------------------------------
module fifo_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_ctrl_v2.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_v2
// Parametrised single-clock FIFO with any depth >= 2, FWFT or registered read,
// programmable almost-full/almost-empty thresholds, exact occupancy count,
// sticky overflow/underflow errors and a synchronous flush.
// Parameters: WIDTH (word bits), DEPTH (entries), FWFT (1 = head word shown
//             without a read, 0 = data one cycle after rd_en).
// Ports:
//   clk           : rising-edge clock
//   async_reset_n : asynchronous active-low reset
//   bus           : fifo_ctrl_v2_if.slave (requests, data, flags, errors)
// Optional feature: define FIFO_PARITY_EN to store an even-parity bit per entry
// and raise the sticky bus.parity_err when a popped word fails its check.
// -----------------------------------------------------------------------------
module fifo_ctrl_v2
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter bit          FWFT  = 1'b1
) (
  input logic           clk,
  input logic           async_reset_n,
  fifo_ctrl_v2_if.slave bus
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);
`ifdef FIFO_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_overflow, r_underflow;
  logic          w_overflow_nxt, w_underflow_nxt;
  logic          w_full, w_empty;
  logic          w_wr_acc, w_rd_acc;
  logic          w_mem_we;
  logic [MW-1:0] w_mem_wdata, w_mem_rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Accept, pointer, count and error next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_full          = (r_count == CW'(DEPTH));
    w_empty         = (r_count == '0);
    w_rd_acc        = bus.rd_en & ~w_empty;
    // A write into a full FIFO is fine when a read frees a slot this cycle.
    w_wr_acc        = bus.wr_en & (~w_full | w_rd_acc);
    w_mem_we        = w_wr_acc & ~bus.flush;

    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    if (w_wr_acc) w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
    if (w_rd_acc) w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    // A new error wins over a coincident clear.
    w_overflow_nxt  = (bus.wr_en & ~w_wr_acc) | (r_overflow & ~bus.clr_err);
    w_underflow_nxt = (bus.rd_en & w_empty) | (r_underflow & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
`ifdef FIFO_PARITY_EN
  assign w_mem_wdata = {even_parity(MaxParW'(bus.wr_data)), bus.wr_data};
`else
  assign w_mem_wdata = bus.wr_data;
`endif

  fifo_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_mem_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

`ifdef FIFO_PARITY_EN
  logic w_par_chk;
  logic w_par_bad;
`endif

  // ---------------------------------------------------------------------------
  // Read side
  // ---------------------------------------------------------------------------
  if (FWFT) begin : g_fwft
    assign bus.rd_data  = w_mem_rdata[WIDTH-1:0];
    assign bus.rd_valid = ~w_empty;
`ifdef FIFO_PARITY_EN
    assign w_par_chk = w_rd_acc;
    assign w_par_bad = even_parity(MaxParW'(w_mem_rdata[WIDTH-1:0])) != w_mem_rdata[MW-1];
`endif
  end else begin : g_reg
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
`ifdef FIFO_PARITY_EN
    logic             r_rd_par;
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
`ifdef FIFO_PARITY_EN
        r_rd_par   <= 1'b0;
`endif
      end else if (bus.flush) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
        // Data holds its last value when nothing is popped.
        if (w_rd_acc) begin
          r_rd_data <= w_mem_rdata[WIDTH-1:0];
`ifdef FIFO_PARITY_EN
          r_rd_par  <= w_mem_rdata[MW-1];
`endif
        end
      end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`ifdef FIFO_PARITY_EN
    assign w_par_chk = r_rd_valid;
    assign w_par_bad = even_parity(MaxParW'(r_rd_data)) != r_rd_par;
`endif
  end

`ifdef FIFO_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_parity_err <= 1'b0;
    end else if (bus.flush) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (w_par_chk & w_par_bad) | (r_parity_err & ~bus.clr_err);
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  // ---------------------------------------------------------------------------
  // Status outputs (thresholds act combinationally on the registered count)
  // ---------------------------------------------------------------------------
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.afull_thr);
  assign bus.almost_empty = (r_count <= bus.aempty_thr);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl_v2
// Drives an FWFT instance and a registered-read instance of fifo_ctrl_v2
// (WIDTH=8, DEPTH=5) with the same stimulus and compares both against a
// queue-based reference model after every clock.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl_v2;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic async_reset_n;

  fifo_ctrl_v2_if #(.WIDTH(W), .DEPTH(D)) if1 ();
  fifo_ctrl_v2_if #(.WIDTH(W), .DEPTH(D)) if0 ();

  fifo_ctrl_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_dut_fwft (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .bus           (if1)
  );

  fifo_ctrl_v2 #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_dut_reg (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .bus           (if0)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, sticky flags, registered-read output.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rvalid;
  logic [W-1:0] m_rdata;
  int           m_afull, m_aempty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  task automatic model_step(input bit fl, input bit we, input logic [W-1:0] wd,
                            input bit re, input bit ce);
    int  n;
    bit  rd_ok, wr_ok;
    if (fl) begin
      q.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      m_rvalid = 1'b0;
    end else begin
      n     = q.size();
      rd_ok = re && (n > 0);
      wr_ok = we && ((n < D) || rd_ok);
      m_rvalid = rd_ok;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(wd);
      m_ovf = (we && !wr_ok) || (m_ovf && !ce);
      m_unf = (re && (n == 0)) || (m_unf && !ce);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, " count_fwft"},  32'(if1.count),        32'(n));
    chk({tag, " count_reg"},   32'(if0.count),        32'(n));
    chk({tag, " empty_fwft"},  32'(if1.empty),        32'(n == 0));
    chk({tag, " empty_reg"},   32'(if0.empty),        32'(n == 0));
    chk({tag, " full_fwft"},   32'(if1.full),         32'(n == D));
    chk({tag, " full_reg"},    32'(if0.full),         32'(n == D));
    chk({tag, " afull_fwft"},  32'(if1.almost_full),  32'(n >= m_afull));
    chk({tag, " afull_reg"},   32'(if0.almost_full),  32'(n >= m_afull));
    chk({tag, " aempty_fwft"}, 32'(if1.almost_empty), 32'(n <= m_aempty));
    chk({tag, " aempty_reg"},  32'(if0.almost_empty), 32'(n <= m_aempty));
    chk({tag, " ovf_fwft"},    32'(if1.overflow),     32'(m_ovf));
    chk({tag, " ovf_reg"},     32'(if0.overflow),     32'(m_ovf));
    chk({tag, " unf_fwft"},    32'(if1.underflow),    32'(m_unf));
    chk({tag, " unf_reg"},     32'(if0.underflow),    32'(m_unf));
    chk({tag, " rvalid_fwft"}, 32'(if1.rd_valid),     32'(n > 0));
    if (n > 0) chk({tag, " rdata_fwft"}, 32'(if1.rd_data), 32'(q[0]));
    chk({tag, " rvalid_reg"},  32'(if0.rd_valid),     32'(m_rvalid));
    chk({tag, " rdata_reg"},   32'(if0.rd_data),      32'(m_rdata));
`ifdef FIFO_PARITY_EN
    chk({tag, " perr_fwft"},   32'(if1.parity_err),   32'(0));
    chk({tag, " perr_reg"},    32'(if0.parity_err),   32'(0));
`endif
  endtask

  task automatic drive(input bit fl, input bit we, input logic [W-1:0] wd,
                       input bit re, input bit ce);
    if1.flush = fl; if1.wr_en = we; if1.wr_data = wd; if1.rd_en = re; if1.clr_err = ce;
    if0.flush = fl; if0.wr_en = we; if0.wr_data = wd; if0.rd_en = re; if0.clr_err = ce;
  endtask

  task automatic set_thr(input int af, input int ae);
    m_afull  = af;
    m_aempty = ae;
    if1.afull_thr = CW'(af); if1.aempty_thr = CW'(ae);
    if0.afull_thr = CW'(af); if0.aempty_thr = CW'(ae);
  endtask

  // One clock with the given request pattern, then model update and full check.
  task automatic cyc(input string tag, input bit fl, input bit we, input logic [W-1:0] wd,
                     input bit re, input bit ce);
    drive(fl, we, wd, re, ce);
    @(posedge clk);
    model_step(fl, we, wd, re, ce);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] wd;
    async_reset_n = 1'b0;
    drive(0, 0, '0, 0, 0);
    set_thr(3, 1);
    model_reset();
    #2;
    check_all("reset");
    #10 async_reset_n = 1'b1;

    // Fill to full, walking the almost flags through counts 1..5.
    for (int i = 1; i <= 5; i++) begin
      wd = W'(i * 'h11);
      cyc("fill", 0, 1, wd, 0, 0);
    end
    chk("full_at_5", 32'(if1.full), 32'(1));
    cyc("sixth_wr", 0, 1, 8'h66, 0, 0);
    chk("ovf_sixth", 32'(if1.overflow), 32'(1));
    chk("cnt_sixth", 32'(if1.count), 32'(5));

    // First pop to count 4, then raise afull threshold; flag drops with no clock.
    cyc("rd", 0, 0, '0, 1, 0);
    set_thr(5, 1);
    #1;
    check_all("thr_chg");
    chk("afull_drop", 32'(if1.almost_full), 32'(0));
    set_thr(3, 1);
    for (int i = 0; i < 4; i++) cyc("drain", 0, 0, '0, 1, 0);
    chk("empty_after_drain", 32'(if1.empty), 32'(1));
    cyc("clr", 0, 0, '0, 0, 1);

    // Refill, then simultaneous write+read while full across the pointer wrap.
    for (int i = 1; i <= 5; i++) begin
      wd = W'(8'h30 + i);
      cyc("refill", 0, 1, wd, 0, 0);
    end
    for (int i = 1; i <= 3; i++) begin
      wd = W'(8'hA0 + i);
      cyc("wr_rd_full", 0, 1, wd, 1, 0);
    end
    chk("full_wr_rd_ovf", 32'(if1.overflow), 32'(0));
    for (int i = 0; i < 5; i++) cyc("drain2", 0, 0, '0, 1, 0);

    // Underflow, clear, then write+read on empty.
    cyc("rd_empty", 0, 0, '0, 1, 0);
    chk("unf_set", 32'(if1.underflow), 32'(1));
    cyc("clr_unf", 0, 0, '0, 0, 1);
    chk("unf_clr", 32'(if1.underflow), 32'(0));
    cyc("wr_rd_empty", 0, 1, 8'hA5, 1, 0);
    chk("wr_rd_empty_cnt", 32'(if1.count), 32'(1));

    // Registered read: data one cycle after rd_en, valid for exactly one cycle.
    cyc("rd_pulse", 0, 0, '0, 1, 0);
    chk("reg_rd_valid", 32'(if0.rd_valid), 32'(1));
    chk("reg_rd_data", 32'(if0.rd_data), 32'(8'hA5));
    cyc("idle", 0, 0, '0, 0, 0);
    chk("reg_rd_valid_drop", 32'(if0.rd_valid), 32'(0));

    // Flush with count 3 and errors pending.
    cyc("rd_empty2", 0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("pre_flush", 0, 1, W'(8'hC0 + i), 0, 0);
    cyc("flush", 1, 1, 8'hFF, 1, 0);
    chk("flush_cnt", 32'(if1.count), 32'(0));
    chk("flush_unf", 32'(if0.underflow), 32'(0));

    // Random traffic with changing thresholds, rare flush and clear.
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      bit we, re, fl, ce;
      pw = (i < 200) ? 70 : 35;
      pr = (i < 200) ? 40 : 70;
      we = ($urandom_range(0, 99) < pw);
      re = ($urandom_range(0, 99) < pr);
      fl = ($urandom_range(0, 49) == 0);
      ce = ($urandom_range(0, 19) == 0);
      wd = W'($urandom);
      if ($urandom_range(0, 15) == 0) set_thr($urandom_range(0, 7), $urandom_range(0, 7));
      cyc("rand", fl, we, wd, re, ce);
    end

    // Asynchronous reset in the middle of a write cycle.
    set_thr(3, 1);
    for (int i = 0; i < 2; i++) cyc("pre_rst", 0, 1, W'(8'hD0 + i), 1, 0);
    drive(0, 1, 8'hEE, 0, 0);
    #3 async_reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    drive(0, 0, '0, 0, 0);
    #3 async_reset_n = 1'b1;
    cyc("post_rst_wr", 0, 1, 8'h5A, 0, 0);
    cyc("post_rst_rd", 0, 0, '0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_v2.md
Name: fifo_ctrl_v2

Overview:
Parametrised single-clock FIFO, successor to the existing 32x32 FIFO, used as the general buffering element between datapath stages.
- Adds non-power-of-two depth and a selectable read mode (first-word-fall-through or registered).
- Adds runtime-programmable almost-full/almost-empty thresholds and an exact occupancy count.
- Adds sticky overflow/underflow error reporting and a synchronous flush.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 32, number of entries (>=2, any integer, not restricted to power of two)
FWFT, 1, 1 = head word visible on rd_data without a read; 0 = registered read, data one cycle after rd_en
CW, $clog2(DEPTH+1), width of count and threshold buses (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
async_reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents, count and errors
wr_en  in  1  write request
wr_data  in  WIDTH  write data
rd_en  in  1  read request
rd_data  out  WIDTH  read data
rd_valid  out  1  rd_data holds a valid word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= afull_thr
almost_empty  out  1  count <= aempty_thr
afull_thr  in  CW  almost-full threshold
aempty_thr  in  CW  almost-empty threshold
count  out  CW  current occupancy
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, rd_valid=0, registered rd_data=0. Memory is not reset. Resulting flags: empty=1, full=0; almost_* follow the thresholds.
- Accept rules: wr_acc = wr_en & (~full | rd_acc); rd_acc = rd_en & ~empty. A simultaneous write and read when full is accepted and count is unchanged. When empty, a simultaneous write and read accepts the write only; the read sets underflow.
- Pointers: increment on accept; wrap from DEPTH-1 to 0 by explicit compare (no power-of-two masking).
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It is registered and never exceeds DEPTH.
- Flags: full, empty, almost_full and almost_empty are combinational from the registered count and the current threshold inputs. Thresholds may change at any cycle and take effect immediately.
- FWFT=1: rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty. rd_en pops the head, and the next word is visible in the same cycle the pointer updates.
- FWFT=0: on rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value. Latency is 1 cycle.
- Write-to-read latency: a word written in cycle N is readable/visible from cycle N+1. There is no same-cycle bypass on empty.
- Errors: overflow <= 1 on wr_en & ~wr_acc; underflow <= 1 on rd_en & empty. Both stay set until clr_err or flush. If clr_err and a new error coincide, the set wins.
- flush: highest priority after reset. It zeroes pointers, count, errors and rd_valid, and ignores wr_en/rd_en in that cycle.
- Reset mid-operation: all state is cleared immediately; memory content is irrelevant after reset.

Optional Feature:
- Macro: FIFO_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from wr_data on write.
  - An additional output, parity_err (1 bit, sticky, reset 0), is set when a popped word's parity mismatches. For FWFT=1 this is checked on rd_acc; for FWFT=0 it is checked on the registered read.
  - parity_err is cleared by clr_err and flush.
- Undefined: no parity storage, no parity_err port; memory is exactly WIDTH bits per entry.

Decomposition:
- Package fifo_pkg:
  - function cnt_width(depth) returning $clog2(depth+1).
  - localparam-style defaults for WIDTH and DEPTH.
  - typedef-free parity helper function.
- Sub-module fifo_ram: simple dual-port memory with one synchronous write port and one asynchronous read port, parametrised by WIDTH and DEPTH.
- Control, count, flags and error logic stay in fifo_ctrl_v2.

Test Plan:
- DEPTH=5, FWFT=1: write 0x11..0x55 -> full=1, count=5. Sixth write -> overflow=1, count stays 5. Reads return 0x11..0x55 in order, then empty=1.
- Full FIFO, wr_en=rd_en=1 for 3 cycles -> count stays 5, overflow=0, read order preserved across the pointer wrap at index 4->0.
- FWFT=0: write 0xA5, then rd_en pulse -> rd_data=0xA5 with rd_valid=1 exactly one cycle later, rd_valid=0 the cycle after.
- Empty FIFO, rd_en=1 -> underflow=1, count=0. clr_err -> underflow=0. Simultaneous wr+rd on empty -> count=1, underflow=1.
- afull_thr=3, aempty_thr=1: count 0..4 -> almost_empty=1 at counts 0-1 and almost_full=1 at counts 3-4. Change afull_thr to 5 at count 4 -> almost_full drops the same cycle.
- Mid-stream flush with count=3 -> next cycle count=0, empty=1, errors=0. Then assert async_reset_n=0 mid-write -> all outputs at reset values immediately.
